sfr_timers: RTL and testbench

Parametrised timer and interrupt special-function-register bank for the b16 SFR space. It provides a shared 32-bit free-running cycle counter, gated by `drun`, and NCH independent compare channels. Each channel has one-shot or periodic auto-reload mode, a pending flag that software clears by writing 1, and a per-channel mask. It sits beside the existing SFR decode on the same 16-bit byte-lane bus and drives the core's interrupt request.

---
 rtl/sfr_timers_if.sv | 24 ++
 rtl/sfr_timers.sv | 151 +++++++++++++++
 tb/tb_sfr_timers.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfr_timers_if.sv
// sfr_timers_if
//   Byte-lane SFR bus bundle shared by the SFR decode (master) and the
//   timer/interrupt bank (slave).
//   drun     : counter enable
//   sel      : block selected by the SFR address decode
//   addr     : byte address, bit 0 ignored by the slave
//   r        : read strobe
//   w        : write byte lanes (w[1] -> dwrite[15:8], w[0] -> dwrite[7:0])
//   dwrite   : write data
//   sfr_data : combinational read data from the slave
//   irq      : level interrupt request from the slave
interface sfr_timers_if;
  logic        drun;
  logic        sel;
  logic [7:0]  addr;
  logic        r;
  logic [1:0]  w;
  logic [15:0] dwrite;
  logic [15:0] sfr_data;
  logic        irq;

  modport master (output drun, sel, addr, r, w, dwrite, input sfr_data, irq);
  modport slave  (input drun, sel, addr, r, w, dwrite, output sfr_data, irq);
endinterface

// File: rtl/sfr_timers.sv
// sfr_timers
//   Timer and interrupt SFR bank: one 32-bit free-running counter gated by
//   drun, plus NCH compare channels with one-shot or periodic reload, a
//   write-1-to-clear pending flag and a per-channel interrupt mask.
//   clk    : system clock, all state updates on posedge
//   nreset : asynchronous active-low reset, clears all state
//   bus    : sfr_timers_if.slave (drun, sel, addr, r, w, dwrite in;
//            sfr_data, irq out)
//   Map: 0x00 {mask,pending} / 0x02 timer hi (+snapshot lo) / 0x04 snapshot
//        0x06 timer lo live / 0x10+8*i channel i: cmp hi, cmp lo, mode, period
module sfr_timers #(
  parameter int NCH = 4
) (
  input  logic        clk,
  input  logic        nreset,
  sfr_timers_if.slave bus
);

  logic [31:0]    timer;
  logic [15:0]    snap;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] en;
  logic [NCH-1:0] periodic;
  logic [31:0]    cmp    [NCH];
  logic [15:0]    period [NCH];

  logic [31:0]    cmp_nxt    [NCH];
  logic [15:0]    period_nxt [NCH];
  logic [NCH-1:0] en_nxt;
  logic [NCH-1:0] per_nxt;

  logic [NCH-1:0] match;
  logic [NCH-1:0] ch_sel;
  logic [NCH-1:0] w1c;
  logic [4:0]     ch_idx;
  logic [1:0]     off;
  logic           ctl_hit;
  logic           ch_hit;
  logic [15:0]    rdata;
  logic           unused_addr0;

  // Address decode: addr[7:3] selects an 8-byte block, addr[2:1] the word.
  // Block 0 is the control block, blocks 2..NCH+1 are the channels.
  assign unused_addr0 = bus.addr[0];
  assign off          = bus.addr[2:1];
  assign ctl_hit      = (bus.addr[7:3] == 5'd0);
  assign ch_idx       = bus.addr[7:3] - 5'd2;
  assign ch_hit       = (bus.addr[7:3] >= 5'd2) && (ch_idx < 5'(NCH));

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_sel[i] = ch_hit && (ch_idx == 5'(i));
      // Compare against the pre-increment counter value.
      match[i]  = en[i] && bus.drun && (timer == cmp[i]);
    end
  end

  assign w1c = (bus.sel && ctl_hit && (off == 2'd0) && bus.w[0]) ?
               bus.dwrite[NCH-1:0] : '0;

  // Hardware update first (reload or en-clear), then software byte-lane
  // writes overwrite only the lanes/fields they touch.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cmp_nxt[i]    = (match[i] && periodic[i]) ? cmp[i] + {16'h0, period[i]} : cmp[i];
      en_nxt[i]     = en[i] && !(match[i] && !periodic[i]);
      per_nxt[i]    = periodic[i];
      period_nxt[i] = period[i];
      if (bus.sel && ch_sel[i]) begin
        case (off)
          2'd0: begin
            if (bus.w[1]) cmp_nxt[i][31:24] = bus.dwrite[15:8];
            if (bus.w[0]) cmp_nxt[i][23:16] = bus.dwrite[7:0];
          end
          2'd1: begin
            if (bus.w[1]) cmp_nxt[i][15:8] = bus.dwrite[15:8];
            if (bus.w[0]) cmp_nxt[i][7:0]  = bus.dwrite[7:0];
          end
          2'd2: begin
            if (bus.w[0]) begin
              en_nxt[i]  = bus.dwrite[0];
              per_nxt[i] = bus.dwrite[1];
            end
          end
          default: begin
            if (bus.w[1]) period_nxt[i][15:8] = bus.dwrite[15:8];
            if (bus.w[0]) period_nxt[i][7:0]  = bus.dwrite[7:0];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      timer    <= '0;
      snap     <= '0;
      mask     <= '0;
      pending  <= '0;
      en       <= '0;
      periodic <= '0;
      for (int i = 0; i < NCH; i++) begin
        cmp[i]    <= '0;
        period[i] <= '0;
      end
    end else begin
      if (bus.drun) timer <= timer + 32'd1;
      // Reading the high half latches the low half so the pair is coherent.
      if (bus.sel && bus.r && ctl_hit && (off == 2'd1)) snap <= timer[15:0];
      if (bus.sel && ctl_hit && (off == 2'd0) && bus.w[1]) mask <= bus.dwrite[8 +: NCH];
      // A match in the same cycle as a clear keeps the flag set.
      pending  <= (pending & ~w1c) | match;
      en       <= en_nxt;
      periodic <= per_nxt;
      for (int i = 0; i < NCH; i++) begin
        cmp[i]    <= cmp_nxt[i];
        period[i] <= period_nxt[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.sel && bus.r) begin
      if (ctl_hit) begin
        case (off)
          2'd0:    rdata = {8'(mask), 8'(pending)};
          2'd1:    rdata = timer[31:16];
          2'd2:    rdata = snap;
          default: rdata = timer[15:0];
        endcase
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_sel[i]) begin
            case (off)
              2'd0:    rdata = cmp[i][31:16];
              2'd1:    rdata = cmp[i][15:0];
              2'd2:    rdata = {14'h0, periodic[i], en[i]};
              default: rdata = period[i];
            endcase
          end
        end
      end
    end
  end

  assign bus.sfr_data = rdata;
  assign bus.irq      = |(pending & mask);

endmodule

// File: tb/tb_sfr_timers.sv
// tb_sfr_timers
//   Bench for sfr_timers: register-map vector table, hand-written match /
//   reload / snapshot / reset sequences, and a randomized phase checked
//   against a behavioural model of the register bank. A second NCH=2
//   instance covers the unmapped-channel behaviour.
module tb_sfr_timers;
  localparam int         NCH    = 4;
  localparam logic [7:0] CHMASK = 8'h0F;

  logic clk    = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;

  sfr_timers_if bif ();
  sfr_timers_if bif2 ();

  sfr_timers #(.NCH(NCH)) dut  (.clk(clk), .nreset(nreset), .bus(bif));
  sfr_timers #(.NCH(2))   dut2 (.clk(clk), .nreset(nreset), .bus(bif2));

  int   n_chk = 0;
  int   n_err = 0;
  logic g_drun;

  // Behavioural model state
  logic [31:0] m_timer;
  logic [15:0] m_snap;
  logic [7:0]  m_mask;
  logic [7:0]  m_pend;
  logic [31:0] m_cmp    [NCH];
  logic [15:0] m_period [NCH];
  logic        m_en     [NCH];
  logic        m_per    [NCH];

  typedef struct packed {
    logic [7:0]  addr;
    logic [1:0]  w;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = '0; m_snap = '0; m_mask = '0; m_pend = '0;
    for (int i = 0; i < NCH; i++) begin
      m_cmp[i] = '0; m_period[i] = '0; m_en[i] = 1'b0; m_per[i] = 1'b0;
    end
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] a);
    int ia, ch;
    ia = int'(a) & 32'hFE;
    if (ia == 0) return {m_mask, m_pend};
    if (ia == 2) return m_timer[31:16];
    if (ia == 4) return m_snap;
    if (ia == 6) return m_timer[15:0];
    if (ia >= 16 && ia < 16 + 8 * NCH) begin
      ch = (ia - 16) / 8;
      case (ia % 8)
        0: return m_cmp[ch][31:16];
        2: return m_cmp[ch][15:0];
        4: return {14'h0, m_per[ch], m_en[ch]};
        default: return m_period[ch];
      endcase
    end
    return 16'h0;
  endfunction

  // One clock of the register bank, from the rules: matches look at the
  // state before the edge, software lane writes override hardware updates,
  // set beats clear on pending.
  task automatic model_step(input logic dr, input logic sl, input logic rd,
                            input logic [7:0] a, input logic [1:0] wl, input logic [15:0] d);
    logic [7:0] hit;
    int ia, ch;
    hit = 8'h00;
    ia  = int'(a) & 32'hFE;
    if (sl && rd && ia == 2) m_snap = m_timer[15:0];
    for (int i = 0; i < NCH; i++) begin
      if (dr && m_en[i] && m_timer == m_cmp[i]) begin
        hit[i] = 1'b1;
        if (m_per[i]) m_cmp[i] = m_cmp[i] + 32'(m_period[i]);
        else          m_en[i]  = 1'b0;
      end
    end
    if (sl) begin
      if (ia == 0) begin
        if (wl[1]) m_mask = d[15:8] & CHMASK;
        if (wl[0]) m_pend = m_pend & ~d[7:0];
      end else if (ia >= 16 && ia < 16 + 8 * NCH) begin
        ch = (ia - 16) / 8;
        case (ia % 8)
          0: begin
            if (wl[1]) m_cmp[ch][31:24] = d[15:8];
            if (wl[0]) m_cmp[ch][23:16] = d[7:0];
          end
          2: begin
            if (wl[1]) m_cmp[ch][15:8] = d[15:8];
            if (wl[0]) m_cmp[ch][7:0]  = d[7:0];
          end
          4: if (wl[0]) begin m_en[ch] = d[0]; m_per[ch] = d[1]; end
          default: begin
            if (wl[1]) m_period[ch][15:8] = d[15:8];
            if (wl[0]) m_period[ch][7:0]  = d[7:0];
          end
        endcase
      end
    end
    m_pend = m_pend | hit;
    if (dr) m_timer = m_timer + 32'd1;
  endtask

  // Drive one bus cycle (called #1 after posedge), compare at negedge
  // against the model and optionally a hand value, then advance the model.
  task automatic step(input logic sl, input logic rd, input logic [7:0] a, input logic [1:0] wl,
                      input logic [15:0] d, input bit hchk, input logic [15:0] hexp, input string name);
    bif.drun = g_drun; bif.sel = sl; bif.r = rd; bif.addr = a; bif.w = wl; bif.dwrite = d;
    @(negedge clk);
    chk("rdata_model", bif.sfr_data, (sl && rd) ? model_read(a) : 16'h0);
    chk("irq_model", bif.irq, |(m_pend & m_mask));
    if (hchk) chk(name, bif.sfr_data, hexp);
    @(posedge clk);
    model_step(g_drun, sl, rd, a, wl, d);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [1:0] wl, input logic [15:0] d);
    step(1'b1, 1'b0, a, wl, d, 1'b0, 16'h0, "");
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] e, input string n);
    step(1'b1, 1'b1, a, 2'b00, 16'h0, 1'b1, e, n);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 2'b00, 16'h0, 1'b0, 16'h0, "");
  endtask

  task automatic idle_until(input logic [31:0] t);
    int guard;
    guard = 0;
    while (m_timer != t && guard < 70000) begin
      idle(1);
      guard++;
    end
    if (m_timer != t) begin
      n_chk++; n_err++;
      $display("FAIL idle_until: timer 0x%0h, target 0x%0h", m_timer, t);
    end
  endtask

  task automatic chk_irq(input logic e, input string n);
    chk(n, bif.irq, e);
  endtask

  task automatic w2(input logic [7:0] a, input logic [1:0] wl, input logic [15:0] d);
    bif2.sel = 1'b1; bif2.r = 1'b0; bif2.addr = a; bif2.w = wl; bif2.dwrite = d;
    @(posedge clk); #1;
    bif2.sel = 1'b0; bif2.w = 2'b00;
  endtask

  task automatic r2(input logic [7:0] a, input logic [15:0] e, input string n);
    bif2.sel = 1'b1; bif2.r = 1'b1; bif2.addr = a; bif2.w = 2'b00;
    #2;
    chk(n, bif2.sfr_data, e);
    bif2.sel = 1'b0; bif2.r = 1'b0;
  endtask

  logic [7:0]  ra;
  logic [31:0] tgt;

  initial begin
    bif.drun = 1'b0; bif.sel = 1'b0; bif.r = 1'b0; bif.addr = 8'h00; bif.w = 2'b00; bif.dwrite = 16'h0;
    bif2.drun = 1'b0; bif2.sel = 1'b0; bif2.r = 1'b0; bif2.addr = 8'h00; bif2.w = 2'b00; bif2.dwrite = 16'h0;
    g_drun = 1'b0;

    vt[0]  = '{8'h10, 2'b11, 16'h1234, 16'h1234};  // ch0 cmp hi
    vt[1]  = '{8'h12, 2'b01, 16'hABCD, 16'h00CD};  // ch0 cmp lo, low lane only
    vt[2]  = '{8'h12, 2'b10, 16'h5600, 16'h56CD};  // ch0 cmp lo, high lane only
    vt[3]  = '{8'h14, 2'b11, 16'hFFFE, 16'h0002};  // mode: only 2 bits stored
    vt[4]  = '{8'h16, 2'b11, 16'hBEEF, 16'hBEEF};  // period
    vt[5]  = '{8'h17, 2'b00, 16'h0000, 16'hBEEF};  // odd address aliases word
    vt[6]  = '{8'h00, 2'b10, 16'hFF00, 16'h0F00};  // mask, unimplemented bits 0
    vt[7]  = '{8'h02, 2'b11, 16'hFFFF, 16'h0000};  // timer hi read-only
    vt[8]  = '{8'h06, 2'b11, 16'h1234, 16'h0000};  // timer lo read-only
    vt[9]  = '{8'h08, 2'b11, 16'h1111, 16'h0000};  // unmapped gap
    vt[10] = '{8'h30, 2'b11, 16'h2222, 16'h0000};  // channel 4 absent
    vt[11] = '{8'h2E, 2'b11, 16'h0707, 16'h0707};  // ch3 period
    vt[12] = '{8'h00, 2'b10, 16'h0000, 16'h0000};  // mask cleared

    // Asynchronous reset with read strobe active: everything reads 0.
    #1 nreset = 1'b0;
    bif.sel = 1'b1; bif.r = 1'b1;
    foreach (vt[i]) begin
      bif.addr = vt[i].addr;
      #0.5;
      chk("reset_rdata", bif.sfr_data, 16'h0);
    end
    chk("reset_irq", bif.irq, 1'b0);
    bif.sel = 1'b0; bif.r = 1'b0;
    model_reset();
    @(negedge clk) nreset = 1'b1;
    @(posedge clk); #1;

    // Strobe qualification
    step(1'b1, 1'b0, 8'h00, 2'b00, 16'h0, 1'b1, 16'h0, "no_read_without_r");

    // Register map table, counter stopped
    for (int i = 0; i < 13; i++) begin
      if (vt[i].w != 2'b00) wr(vt[i].addr, vt[i].w, vt[i].wdata);
      rd(vt[i].addr, vt[i].exp, $sformatf("map_%0d", i));
    end

    // One-shot on ch0 at timer 0x10
    wr(8'h10, 2'b11, 16'h0000);
    wr(8'h12, 2'b11, 16'h0010);
    wr(8'h14, 2'b01, 16'h0001);
    wr(8'h00, 2'b10, 16'h0100);
    g_drun = 1'b1;
    idle(16);
    chk_irq(1'b0, "oneshot_before");
    idle(1);
    chk_irq(1'b1, "oneshot_irq");
    rd(8'h00, 16'h0101, "oneshot_pending");
    rd(8'h14, 16'h0000, "oneshot_en_cleared");
    wr(8'h00, 2'b01, 16'h0001);
    chk_irq(1'b0, "oneshot_w1c");

    // Periodic on ch1: 0x20, 0x30, 0x40
    wr(8'h18, 2'b11, 16'h0000);
    wr(8'h1A, 2'b11, 16'h0020);
    wr(8'h1E, 2'b11, 16'h0010);
    wr(8'h1C, 2'b01, 16'h0003);
    wr(8'h00, 2'b10, 16'h0200);
    idle_until(32'h20);
    chk_irq(1'b0, "periodic_before");
    idle(1);
    chk_irq(1'b1, "periodic_irq1");
    rd(8'h1A, 16'h0030, "periodic_cmp1");
    wr(8'h00, 2'b01, 16'h0002);
    chk_irq(1'b0, "periodic_w1c");
    idle_until(32'h30);
    idle(1);
    chk_irq(1'b1, "periodic_irq2");
    rd(8'h1A, 16'h0040, "periodic_cmp2");
    wr(8'h00, 2'b01, 16'h0002);
    idle_until(32'h40);
    idle(1);
    rd(8'h1A, 16'h0050, "periodic_cmp3");
    rd(8'h18, 16'h0000, "periodic_cmp3_hi");
    rd(8'h1C, 16'h0003, "periodic_still_en");
    wr(8'h1C, 2'b01, 16'h0000);
    wr(8'h00, 2'b01, 16'h0002);

    // Gating and masking on ch2
    idle_until(32'h50);
    g_drun = 1'b0;
    wr(8'h20, 2'b11, 16'h0000);
    wr(8'h22, 2'b11, 16'h0050);
    wr(8'h24, 2'b01, 16'h0001);
    wr(8'h00, 2'b10, 16'h0000);
    idle(5);
    rd(8'h00, 16'h0000, "gate_no_pending");
    rd(8'h06, 16'h0050, "gate_timer_held");
    g_drun = 1'b1;
    idle(1);
    chk_irq(1'b0, "masked_irq");
    rd(8'h00, 16'h0004, "masked_pending");
    wr(8'h00, 2'b10, 16'h0400);
    chk_irq(1'b1, "unmask_irq");

    // Simultaneous events on ch2 (periodic, period 8)
    wr(8'h22, 2'b11, 16'h0060);
    wr(8'h26, 2'b11, 16'h0008);
    wr(8'h24, 2'b01, 16'h0003);
    idle_until(32'h60);
    wr(8'h00, 2'b01, 16'h0004);
    chk_irq(1'b1, "set_beats_clear_irq");
    rd(8'h00, 16'h0404, "set_beats_clear_pending");
    idle_until(32'h68);
    wr(8'h22, 2'b11, 16'h0100);
    rd(8'h22, 16'h0100, "sw_write_wins");
    idle_until(32'h100);
    wr(8'h22, 2'b10, 16'h0300);
    rd(8'h22, 16'h0308, "sw_lane_merge");
    wr(8'h24, 2'b01, 16'h0000);
    wr(8'h00, 2'b01, 16'h00FF);
    wr(8'h00, 2'b10, 16'h0000);

    // Reload carry into the high half (ch3), then snapshot coherency
    wr(8'h28, 2'b11, 16'h0000);
    wr(8'h2A, 2'b11, 16'hFFF8);
    wr(8'h2E, 2'b11, 16'h0010);
    wr(8'h2C, 2'b01, 16'h0003);
    wr(8'h00, 2'b10, 16'h0800);
    idle_until(32'hFFF8);
    idle(1);
    chk_irq(1'b1, "carry_irq");
    rd(8'h28, 16'h0001, "carry_cmp_hi");
    rd(8'h2A, 16'h0008, "carry_cmp_lo");
    wr(8'h00, 2'b01, 16'h0008);
    idle_until(32'hFFFF);
    rd(8'h02, 16'h0000, "snap_hi_read");
    rd(8'h04, 16'hFFFF, "snap_coherent");
    rd(8'h06, 16'h0001, "timer_lo_moved");
    rd(8'h04, 16'hFFFF, "snap_held");
    idle_until(32'h0001_0008);
    idle(1);
    chk_irq(1'b1, "carry_rematch");
    rd(8'h2A, 16'h0018, "carry_reload2");
    wr(8'h2C, 2'b01, 16'h0000);
    wr(8'h00, 2'b01, 16'h00FF);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      int op, ch;
      op     = int'($urandom_range(0, 9));
      ch     = int'($urandom_range(0, NCH - 1));
      g_drun = ($urandom_range(0, 9) < 8);
      case (op)
        0, 1: idle(1);
        2, 3: begin
          ra = 8'($urandom_range(0, 79));
          step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, 2'b00, 16'h0, 1'b0, 16'h0, "");
        end
        4: begin
          ra = 8'($urandom_range(0, 79));
          step(1'b1, 1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)),
               16'($urandom), 1'b0, 16'h0, "");
        end
        5: wr(8'(16 + 8 * ch), 2'b11, m_timer[31:16]);
        6: wr(8'(18 + 8 * ch), 2'b11, m_timer[15:0] + 16'($urandom_range(1, 6)));
        7: wr(8'(20 + 8 * ch), 2'b01, 16'($urandom_range(0, 3)));
        8: wr(8'h00, 2'b01, 16'($urandom_range(0, 255)));
        default: wr(8'h00, 2'b10, 16'($urandom_range(0, 255)) << 8);
      endcase
    end

    // Reset in the middle of a cycle with irq high
    g_drun = 1'b1;
    tgt = m_timer + 32'd12;
    wr(8'h10, 2'b11, tgt[31:16]);
    wr(8'h12, 2'b11, tgt[15:0]);
    wr(8'h14, 2'b01, 16'h0001);
    wr(8'h00, 2'b10, 16'h0100);
    idle_until(tgt);
    idle(1);
    chk_irq(1'b1, "pre_reset_irq");
    bif.drun = 1'b0; bif.sel = 1'b1; bif.r = 1'b1; bif.w = 2'b00; bif.addr = 8'h06;
    #2 nreset = 1'b0;
    #0.5;
    chk("midreset_irq", bif.irq, 1'b0);
    chk("midreset_timer", bif.sfr_data, 16'h0);
    bif.addr = 8'h10;
    #0.5;
    chk("midreset_cmp", bif.sfr_data, 16'h0);
    bif.addr = 8'h00;
    #0.5;
    chk("midreset_ctl", bif.sfr_data, 16'h0);
    model_reset();
    g_drun = 1'b0;
    bif.addr = 8'h10;
    @(negedge clk) nreset = 1'b1;
    @(posedge clk); #1;
    rd(8'h06, 16'h0000, "post_reset_timer");

    // NCH=2 instance: channel 2 and up are unmapped
    w2(8'h20, 2'b11, 16'hAAAA);
    r2(8'h20, 16'h0000, "nch2_unmapped_cmp");
    w2(8'h24, 2'b01, 16'h0003);
    r2(8'h24, 16'h0000, "nch2_unmapped_mode");
    w2(8'h00, 2'b10, 16'hFF00);
    r2(8'h00, 16'h0300, "nch2_mask_bits");
    w2(8'h18, 2'b11, 16'h1357);
    r2(8'h18, 16'h1357, "nch2_ch1_cmp");
    chk("nch2_irq", bif2.irq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
